// File: rtl/mmio_io_pkg.sv
// Shared definitions for the MMIO I/O controller: register offsets, bit indices, encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mmio_io_pkg;

  // Byte offsets inside the 256-byte window (decoded on addr[7:2])
  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_KEY    = 8'h04;
  localparam logic [7:0] OFF_NUM    = 8'h08;
  localparam logic [7:0] OFF_LED    = 8'h0C;
  localparam logic [7:0] OFF_VGA    = 8'h10;
  localparam logic [7:0] OFF_CTRL   = 8'h14;

  // STATUS bit positions
  localparam int ST_NUM_VALID = 0;
  localparam int ST_NOT_EMPTY = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_COUNT_LO  = 4;
  localparam int ST_IRQ_MASK  = 8;

  // CTRL bit positions
  localparam int CTRL_CLR_OVF  = 0;
  localparam int CTRL_FLUSH    = 1;
  localparam int CTRL_IRQ_MASK = 2;

  // Result shown by the VGA block
  typedef enum logic [1:0] {
    VGA_NONE = 2'd0,
    VGA_ODD  = 2'd1,
    VGA_EVEN = 2'd2
  } vga_result_e;

  // Occupancy counter needs one bit more than the pointers to represent "full"
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mmio_io_ctrl_key_event_fifo.sv
// Synchronous key-event FIFO with push/pop/flush and drop-on-full overflow pulse.
// Latency: push visible at head one cycle later; head is combinational from storage.
// Backpressure: none; a push into a full FIFO without a simultaneous pop is dropped and flagged.
import mmio_io_pkg::*;

module key_event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop,
  input  logic                         flush,
  output logic [W-1:0]                 head_dat,
  output logic                         empty,
  output logic                         full,
  output logic [fifo_cnt_w(DEPTH)-1:0] count,
  output logic                         ovf_pulse
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign head_dat = mem[rd_ptr];
  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign ovf_pulse = push && full && !do_pop && !flush;

  // Storage write; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointer and occupancy update; flush overrides any same-cycle push/pop
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// MMIO controller: key FIFO, number buffer, LED and VGA-result registers for the CPU bus.
// Latency: reads return one cycle after bus_re; writes land at the bus_we edge.
// Backpressure: none on the bus; key events are dropped (overflow flagged) when the FIFO is full.
// Optional: define MMIO_IRQ_EN to add irq_out and the CTRL[2]/STATUS[8] IRQ mask.
import mmio_io_pkg::*;

module mmio_io_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          LED_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      bus_addr,
  input  logic             bus_re,
  input  logic             bus_we,
  input  logic [31:0]      bus_wdata,
  output logic             bus_hit,
  output logic [31:0]      bus_rdata,
  input  logic [7:0]       scancode_in,
  input  logic             key_pressed_in,
  input  logic [31:0]      num_in,
  input  logic             num_valid_in,
  output logic             num_read_ack,
  output logic [LED_W-1:0] led_out,
  output logic [1:0]       vga_result_out
`ifdef MMIO_IRQ_EN
  ,
  output logic             irq_out
`endif
);

  localparam int CW = fifo_cnt_w(FIFO_DEPTH);

  logic [7:0]    off;
  logic          rd_en;
  logic          wr_en;
  logic          key_pop;
  logic          ctrl_wr;
  logic          flush;
  logic [7:0]    head_dat;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          ovf_pulse;
  logic          ovf_q;
  logic [3:0]    cnt_sat;
  logic [31:0]   status_val;
  logic [31:0]   rd_mux;
  vga_result_e   vga_q;
  logic          unused_bits;

  assign bus_hit = (bus_addr[31:8] == BASE_ADDR[31:8]);
  assign off     = {bus_addr[7:2], 2'b00};
  // A write in the same cycle as a read suppresses the read entirely
  assign rd_en   = bus_re && bus_hit && !bus_we;
  assign wr_en   = bus_we && bus_hit;
  assign key_pop = rd_en && (off == OFF_KEY);
  assign ctrl_wr = wr_en && (off == OFF_CTRL);
  assign flush   = ctrl_wr && bus_wdata[CTRL_FLUSH];

  assign vga_result_out = vga_q;
  assign unused_bits    = ^{bus_addr[1:0], bus_wdata};

  key_event_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (key_pressed_in),
    .push_dat (scancode_in),
    .pop      (key_pop),
    .flush    (flush),
    .head_dat (head_dat),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count),
    .ovf_pulse(ovf_pulse)
  );

`ifdef MMIO_IRQ_EN
  logic irq_mask_q;

  // IRQ mask lives in CTRL[2]; starts masked
  always_ff @(posedge clk) begin
    if (!rst)         irq_mask_q <= 1'b1;
    else if (ctrl_wr) irq_mask_q <= bus_wdata[CTRL_IRQ_MASK];
  end

  // Level interrupt: pending key or number, unless masked
  always_ff @(posedge clk) begin
    if (!rst) irq_out <= 1'b0;
    else      irq_out <= !irq_mask_q && (!fifo_empty || num_valid_in);
  end
`endif

  // STATUS word assembly; count saturates into its 4-bit field
  always_comb begin
    if (32'(fifo_count) > 32'd15) cnt_sat = 4'hF;
    else                          cnt_sat = 4'(fifo_count);
    status_val = '0;
    status_val[ST_NUM_VALID]     = num_valid_in;
    status_val[ST_NOT_EMPTY]     = !fifo_empty;
    status_val[ST_OVERFLOW]      = ovf_q;
    status_val[ST_COUNT_LO +: 4] = cnt_sat;
`ifdef MMIO_IRQ_EN
    status_val[ST_IRQ_MASK]      = irq_mask_q;
`endif
  end

  // Read mux; KEY returns 0 when empty so a racing push is never observed early
  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_STATUS: rd_mux = status_val;
      OFF_KEY:    rd_mux = fifo_empty ? 32'd0 : {24'd0, head_dat};
      OFF_NUM:    rd_mux = num_in;
      OFF_LED:    rd_mux = 32'(led_out);
      OFF_VGA:    rd_mux = {30'd0, vga_q};
      default:    rd_mux = '0;
    endcase
  end

  // Registered read data and number-buffer acknowledge
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_rdata    <= '0;
      num_read_ack <= 1'b0;
    end else begin
      if (rd_en) bus_rdata <= rd_mux;
      num_read_ack <= rd_en && (off == OFF_NUM) && num_valid_in;
    end
  end

  // LED and VGA-result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      led_out <= '0;
      vga_q   <= VGA_NONE;
    end else begin
      if (wr_en && (off == OFF_LED)) led_out <= bus_wdata[LED_W-1:0];
      if (wr_en && (off == OFF_VGA)) vga_q   <= vga_result_e'(bus_wdata[1:0]);
    end
  end

  // Sticky overflow flag; a new drop beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst)                                      ovf_q <= 1'b0;
    else if (ovf_pulse)                            ovf_q <= 1'b1;
    else if (ctrl_wr && bus_wdata[CTRL_CLR_OVF])   ovf_q <= 1'b0;
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench for mmio_io_ctrl with a read scoreboard and a reference FIFO model.
// Latency: expects bus_rdata/num_read_ack one cycle after each read strobe.
// Backpressure: n/a.
module tb_mmio_io_ctrl;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic [31:0] bus_addr;
  logic        bus_re;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic        bus_hit;
  logic [31:0] bus_rdata;
  logic [7:0]  scancode_in;
  logic        key_pressed_in;
  logic [31:0] num_in;
  logic        num_valid_in;
  logic        num_read_ack;
  logic [15:0] led_out;
  logic [1:0]  vga_result_out;
`ifdef MMIO_IRQ_EN
  logic        irq_out;
`endif

  mmio_io_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .bus_addr      (bus_addr),
    .bus_re        (bus_re),
    .bus_we        (bus_we),
    .bus_wdata     (bus_wdata),
    .bus_hit       (bus_hit),
    .bus_rdata     (bus_rdata),
    .scancode_in   (scancode_in),
    .key_pressed_in(key_pressed_in),
    .num_in        (num_in),
    .num_valid_in  (num_valid_in),
    .num_read_ack  (num_read_ack),
    .led_out       (led_out),
    .vga_result_out(vga_result_out)
`ifdef MMIO_IRQ_EN
    ,
    .irq_out       (irq_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        ack;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mq[$];
  bit          movf;
  bit          mmask;
  logic [15:0] m_led;
  logic [1:0]  m_vga;
  logic [31:0] last_rdata;
  int          n_tests;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int          c;
    c = (mq.size() > 15) ? 15 : mq.size();
    s = 32'(c) << 4;
    s[0] = num_valid_in;
    s[1] = (mq.size() != 0);
    s[2] = movf;
`ifdef MMIO_IRQ_EN
    s[8] = mmask;
`endif
    return s;
  endfunction

  task automatic model_reset();
    mq.delete();
    movf  = 1'b0;
    mmask = 1'b1;
    m_led = '0;
    m_vga = '0;
  endtask

  // One bus cycle: compute expectations from the model, update the model, drive, advance
  task automatic access(input bit re, input bit we, input logic [7:0] off,
                        input logic [31:0] wd, input bit key, input logic [7:0] code,
                        input string tag);
    logic [31:0] rexp;
    bit          rd;
    bit          flush;
    bit          set_ovf;
    rd   = re && !we;
    rexp = '0;
    if (rd) begin
      case (off)
        8'h00:   rexp = exp_status();
        8'h04:   rexp = (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0;
        8'h08:   rexp = num_in;
        8'h0C:   rexp = {16'd0, m_led};
        8'h10:   rexp = {30'd0, m_vga};
        default: rexp = '0;
      endcase
      sb.push_back('{tag, rexp, num_valid_in && (off == 8'h08)});
      if (off == 8'h04 && mq.size() != 0) void'(mq.pop_front());
    end
    flush   = we && (off == 8'h14) && wd[1];
    set_ovf = key && (mq.size() >= DEPTH) && !flush;
    if (key && mq.size() < DEPTH) mq.push_back(code);
    if (flush) mq.delete();
    if (we && off == 8'h14) begin
      if (wd[0]) movf = 1'b0;
      mmask = wd[2];
    end
    if (set_ovf) movf = 1'b1;
    if (we && off == 8'h0C) m_led = wd[15:0];
    if (we && off == 8'h10) m_vga = wd[1:0];

    bus_addr       = 32'hFFFF_0000 | {24'd0, off};
    bus_re         = re;
    bus_we         = we;
    bus_wdata      = wd;
    key_pressed_in = key;
    scancode_in    = code;
    @(negedge clk);
    bus_re         = 1'b0;
    bus_we         = 1'b0;
    key_pressed_in = 1'b0;
  endtask

  // Scoreboard: every accepted read produces one registered result
  always @(posedge clk) begin
    exp_t e;
    if (rst && bus_re && !bus_we) begin
      #1;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_rdata"}, bus_rdata, e.data);
        chk({e.tag, "_ack"}, {31'd0, num_read_ack}, {31'd0, e.ack});
        last_rdata = e.data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; last_rdata = '0;
    rst = 1'b0; bus_addr = '0; bus_re = 0; bus_we = 0; bus_wdata = '0;
    scancode_in = '0; key_pressed_in = 0; num_in = '0; num_valid_in = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_rdata", bus_rdata, 32'd0);
    chk("rst_ack", {31'd0, num_read_ack}, 32'd0);
    chk("rst_led", {16'd0, led_out}, 32'd0);
    chk("rst_vga", {30'd0, vga_result_out}, 32'd0);
    rst = 1'b1;
    bus_addr = 32'h1234_0008; #1 chk("hit_outside", {31'd0, bus_hit}, 32'd0);
    bus_addr = 32'hFFFF_00FC; #1 chk("hit_inside", {31'd0, bus_hit}, 32'd1);
    @(negedge clk);

    // Reset-state register reads
    access(1, 0, 8'h00, 0, 0, 0, "rd_status0");
    access(1, 0, 8'h0C, 0, 0, 0, "rd_led0");
    access(1, 0, 8'h10, 0, 0, 0, "rd_vga0");

    // Ordered key delivery, then empty read
    access(0, 0, 8'h00, 0, 1, 8'h16, "push");
    access(0, 0, 8'h00, 0, 1, 8'h1E, "push");
    access(0, 0, 8'h00, 0, 1, 8'h26, "push");
    access(1, 0, 8'h00, 0, 0, 0, "st_cnt3");
    for (int i = 0; i < 3; i++) access(1, 0, 8'h04, 0, 0, 0, "rd_key");
    access(1, 0, 8'h00, 0, 0, 0, "st_cnt0");
    access(1, 0, 8'h04, 0, 0, 0, "rd_key_empty");

    // Overflow, clear, and full push+pop
    for (int i = 0; i < 9; i++) access(0, 0, 8'h00, 0, 1, 8'h40 + 8'(i), "push");
    access(1, 0, 8'h00, 0, 0, 0, "st_full_ovf");
    access(0, 1, 8'h14, 32'h1, 0, 0, "clr_ovf");
    access(1, 0, 8'h00, 0, 0, 0, "st_ovf_clr");
    access(1, 0, 8'h04, 0, 1, 8'h50, "full_pushpop");
    access(1, 0, 8'h00, 0, 0, 0, "st_after_pushpop");
    for (int i = 0; i < 8; i++) access(1, 0, 8'h04, 0, 0, 0, "drain_key");

    // Push into empty with same-cycle KEY read
    access(1, 0, 8'h04, 0, 1, 8'h33, "empty_pushpop");
    access(1, 0, 8'h04, 0, 0, 0, "rd_key_33");

    // Number buffer with and without valid
    num_in = 32'd12345; num_valid_in = 1'b1;
    access(1, 0, 8'h00, 0, 0, 0, "st_numvalid");
    access(1, 0, 8'h08, 0, 0, 0, "rd_num_valid");
    @(negedge clk);
    chk("ack_one_cycle", {31'd0, num_read_ack}, 32'd0);
    num_valid_in = 1'b0;
    access(1, 0, 8'h08, 0, 0, 0, "rd_num_invalid");

    // LED/VGA registers, write-wins collision, unmapped offsets
    access(0, 1, 8'h0C, 32'h0000_A5A5, 0, 0, "wr_led");
    access(0, 1, 8'h10, 32'h2, 0, 0, "wr_vga");
    chk("led_out", {16'd0, led_out}, 32'h0000_A5A5);
    chk("vga_out", {30'd0, vga_result_out}, 32'd2);
    access(1, 0, 8'h0C, 0, 0, 0, "rd_led");
    access(1, 0, 8'h10, 0, 0, 0, "rd_vga");
    access(0, 0, 8'h00, 0, 1, 8'h55, "push");
    access(1, 1, 8'h04, 32'h1, 0, 0, "collide");
    access(0, 1, 8'h0C, 32'h1, 0, 0, "wr_led1");
    chk("collide_rdata_hold", bus_rdata, last_rdata);
    chk("led_after_wr", {16'd0, led_out}, 32'h1);
    access(1, 0, 8'h00, 0, 0, 0, "st_collide");
    access(0, 1, 8'h14, 32'h2, 1, 8'h66, "flush_push");
    access(1, 0, 8'h00, 0, 0, 0, "st_flushed");
    access(0, 1, 8'h3C, 32'hFFFF_FFFF, 0, 0, "wr_unmapped");
    access(1, 0, 8'h3C, 0, 0, 0, "rd_unmapped");
    access(1, 0, 8'h14, 0, 0, 0, "rd_ctrl");

    // Reset asserted during a NUM read with valid
    access(0, 1, 8'h0C, 32'h0000_5A5A, 0, 0, "wr_led");
    access(0, 1, 8'h10, 32'h1, 0, 0, "wr_vga");
    access(0, 0, 8'h00, 0, 1, 8'h77, "push");
    num_valid_in = 1'b1;
    bus_addr = 32'hFFFF_0008; bus_re = 1'b1; rst = 1'b0;
    @(negedge clk);
    bus_re = 1'b0;
    chk("midrst_rdata", bus_rdata, 32'd0);
    chk("midrst_ack", {31'd0, num_read_ack}, 32'd0);
    chk("midrst_led", {16'd0, led_out}, 32'd0);
    chk("midrst_vga", {30'd0, vga_result_out}, 32'd0);
    model_reset();
    rst = 1'b1;
    access(1, 0, 8'h00, 0, 0, 0, "st_after_rst");
    num_valid_in = 1'b0;

`ifdef MMIO_IRQ_EN
    access(0, 1, 8'h14, 32'h0, 0, 0, "unmask");
    chk("irq_idle", {31'd0, irq_out}, 32'd0);
    access(0, 0, 8'h00, 0, 1, 8'h12, "push");
    chk("irq_not_yet", {31'd0, irq_out}, 32'd0);
    @(negedge clk);
    chk("irq_rise", {31'd0, irq_out}, 32'd1);
    access(1, 0, 8'h04, 0, 0, 0, "irq_pop");
    chk("irq_hold", {31'd0, irq_out}, 32'd1);
    @(negedge clk);
    chk("irq_fall", {31'd0, irq_out}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
